// File: rtl/mux_pkg.sv
// Shared definitions for the mux_scan block.
//   state_t : controller state encoding (IDLE / MANUAL / SCAN)
//   clog2   : ceiling log2, used to size channel indices and counters
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3, clog2(256) = 8.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Scan position tracker: dwell counter plus current scan channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the scan at load_val with the dwell count cleared
//   load_val   : start channel, already range-checked by the caller
//   run        : take one scan sample this edge (advance dwell / channel)
//   ch         : channel sampled on this edge (the position after the update)
//   wrap       : this edge moves the scan from CHANNELS-1 back to 0
// ch and wrap are combinational views of the next position so the caller can
// register the matching sample on the same edge the position updates.
module scan_counter
  import mux_pkg::*;
#(
  parameter int unsigned  CHANNELS = 8,
  parameter int unsigned  DWELL    = 4,
  localparam int unsigned SELW     = clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  input  logic            run,
  output logic [SELW-1:0] ch,
  output logic            wrap
);

  localparam int unsigned     DW      = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);
  localparam logic [DW-1:0]   DW_LAST = DW'(DWELL - 1);

  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ch_d;
  logic [DW-1:0]   dwell_q;
  logic [DW-1:0]   dwell_d;

  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    wrap    = 1'b0;
    if (load) begin
      ch_d    = load_val;
      dwell_d = '0;
    end else if (run) begin
      if (dwell_q == DW_LAST) begin
        dwell_d = '0;
        // Wrap explicitly at CHANNELS-1 so non-power-of-2 counts never visit
        // the unused indices.
        if (ch_q == CH_LAST) begin
          ch_d = '0;
          wrap = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  assign ch = ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      dwell_q <= '0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select and automatic scan.
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : CHANNELS packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        : manual channel select / scan start channel
//   mode       : 0 = manual, 1 = auto-scan
//   en         : global enable (0 parks the block in IDLE)
//   out        : registered sample
//   out_ch     : channel that produced out
//   out_valid  : out/out_ch carry a fresh sample
//   wrap       : one-cycle pulse on the first sample of channel 0 after a wrap
//   sel_err    : manual select pointed past the last channel
module mux_scan
  import mux_pkg::*;
#(
  parameter int unsigned  WIDTH    = 8,
  parameter int unsigned  CHANNELS = 8,
  parameter int unsigned  DWELL    = 4,
  localparam int unsigned SELW     = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           out_ch,
  output logic                      out_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int unsigned SLOTS = 1 << SELW;

  // Channel table padded to the full index range; sel_ok_map flags which
  // indices are real channels, avoiding a range compare on sel.
  logic [WIDTH-1:0] chan [SLOTS];
  logic [SLOTS-1:0] sel_ok_map;

  for (genvar k = 0; k < SLOTS; k++) begin : g_chan
    if (k < CHANNELS) begin : g_used
      assign chan[k]       = in[k*WIDTH +: WIDTH];
      assign sel_ok_map[k] = 1'b1;
    end else begin : g_pad
      assign chan[k]       = '0;
      assign sel_ok_map[k] = 1'b0;
    end
  end

  state_t          state;
  state_t          nstate;
  logic            resume_ok;
  logic            sel_ok;
  logic [SELW-1:0] load_val;
  logic            load;
  logic            run;
  logic [SELW-1:0] scan_ch;
  logic            scan_wrap;

  // Outputs are registered according to the state being entered on this
  // edge, so a mode/enable change takes effect on the very next sample.
  always_comb begin
    nstate = IDLE;
    if (en) begin
      nstate = mode ? SCAN : MANUAL;
    end
  end

  assign sel_ok   = sel_ok_map[sel];
  assign load_val = sel_ok ? sel : '0;
  assign run      = (nstate == SCAN);
  // resume_ok survives an enable pause with mode held at 1; any cycle with
  // mode=0 (or a reset) forces the next scan entry to reload from sel.
  assign load     = run && (state != SCAN) && !resume_ok;

  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .run      (run),
    .ch       (scan_ch),
    .wrap     (scan_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      resume_ok <= 1'b0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state <= nstate;

      if (!mode) begin
        resume_ok <= 1'b0;
      end else if (run) begin
        resume_ok <= 1'b1;
      end

      unique case (nstate)
        MANUAL: begin
          wrap <= 1'b0;
          if (sel_ok) begin
            out       <= chan[sel];
            out_ch    <= sel;
            out_valid <= 1'b1;
            sel_err   <= 1'b0;
          end else begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b1;
          end
        end
        SCAN: begin
          out       <= chan[scan_ch];
          out_ch    <= scan_ch;
          out_valid <= 1'b1;
          wrap      <= scan_wrap;
          sel_err   <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          wrap      <= 1'b0;
          sel_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three instances (8ch/dwell 4, 5ch/dwell 4, 8ch/dwell 1)
// share control inputs and are compared every cycle against a position-based
// reference model, with extra directed checks on key scenarios.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [2:0]  sel;
  logic [63:0] in0;
  logic [39:0] in1;
  logic [63:0] in2;

  logic [7:0]  out0, out1, out2;
  logic [2:0]  ch0, ch1, ch2;
  logic        v0, v1, v2, w0, w1, w2, e0, e1, e2;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .sel(sel), .mode(mode), .en(en),
    .out(out0), .out_ch(ch0), .out_valid(v0), .wrap(w0), .sel_err(e0));

  mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .mode(mode), .en(en),
    .out(out1), .out_ch(ch1), .out_valid(v1), .wrap(w1), .sel_err(e1));

  mux_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel), .mode(mode), .en(en),
    .out(out2), .out_ch(ch2), .out_valid(v2), .wrap(w2), .sel_err(e2));

  int errors = 0;
  int checks = 0;

  int nc [3] = '{8, 5, 8};
  int nd [3] = '{4, 4, 1};

  // Reference: scan position = samples taken since the scan started.
  int m_out [3], m_ch [3], m_v [3], m_w [3], m_e [3];
  int m_start [3], m_pos [3], m_res [3];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int data(input int i, input int k);
    case (i)
      0:       return int'((in0 >> (k * 8)) & 64'hff);
      1:       return int'((in1 >> (k * 8)) & 40'hff);
      default: return int'((in2 >> (k * 8)) & 64'hff);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 0; m_ch[i] = 0; m_v[i] = 0; m_w[i] = 0; m_e[i] = 0;
      m_start[i] = 0; m_pos[i] = 0; m_res[i] = 0;
    end
  endtask

  task automatic model_edge();
    int s;
    int c;
    s = int'(sel);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!en) begin
          m_v[i] = 0; m_w[i] = 0; m_e[i] = 0;
        end else if (!mode) begin
          m_w[i] = 0;
          if (s >= nc[i]) begin
            m_out[i] = 0; m_v[i] = 0; m_e[i] = 1;
          end else begin
            m_out[i] = data(i, s); m_ch[i] = s; m_v[i] = 1; m_e[i] = 0;
          end
        end else begin
          if (m_res[i] == 0) begin
            m_start[i] = (s < nc[i]) ? s : 0;
            m_pos[i]   = 0;
          end else begin
            m_pos[i]++;
          end
          c = (m_start[i] + m_pos[i] / nd[i]) % nc[i];
          m_out[i] = data(i, c);
          m_ch[i]  = c;
          m_v[i]   = 1;
          m_e[i]   = 0;
          m_w[i]   = (m_pos[i] > 0 && m_pos[i] % nd[i] == 0 && c == 0) ? 1 : 0;
        end
        if (!mode)   m_res[i] = 0;
        else if (en) m_res[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("u0.out", int'(out0), m_out[0]);  chk("u0.out_ch", int'(ch0), m_ch[0]);
    chk("u0.valid", int'(v0), m_v[0]);    chk("u0.wrap", int'(w0), m_w[0]);
    chk("u0.sel_err", int'(e0), m_e[0]);
    chk("u1.out", int'(out1), m_out[1]);  chk("u1.out_ch", int'(ch1), m_ch[1]);
    chk("u1.valid", int'(v1), m_v[1]);    chk("u1.wrap", int'(w1), m_w[1]);
    chk("u1.sel_err", int'(e1), m_e[1]);
    chk("u2.out", int'(out2), m_out[2]);  chk("u2.out_ch", int'(ch2), m_ch[2]);
    chk("u2.valid", int'(v2), m_v[2]);    chk("u2.wrap", int'(w2), m_w[2]);
    chk("u2.sel_err", int'(e2), m_e[2]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_in();
    logic [63:0] t;
    in0 = {$urandom, $urandom};
    in2 = {$urandom, $urandom};
    t   = {$urandom, $urandom};
    in1 = t[39:0];
  endtask

  int held;

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0;
    rand_in();
    model_reset();

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    step();

    // Manual directed: channel k = 8'h10+k, sel = 6
    in0  = 64'h17161514_13121110;
    in1  = 40'h14_13121110;
    in2  = 64'h17161514_13121110;
    sel  = 3'b110; mode = 1'b0; en = 1'b1;
    step();
    chk("man_out", int'(out0), 'h16);
    chk("man_ch", int'(ch0), 6);
    chk("man_valid", int'(v0), 1);
    chk("np2_err", int'(e1), 1);
    chk("np2_valid", int'(v1), 0);
    chk("np2_out", int'(out1), 0);

    // Random manual traffic (includes out-of-range selects on the 5ch unit)
    for (int k = 0; k < 20; k++) begin
      sel = 3'($urandom_range(0, 7));
      rand_in();
      step();
    end

    // Scan from channel 5, dwell 4: 5 x4, 6 x4, 7 x4, then 0 with wrap
    sel = 3'd5; mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rand_in();
      step();
      if (k < 16) begin
        chk("scan_ch", int'(ch0), (5 + k / 4) % 8);
        chk("scan_wrap", int'(w0), (k == 12) ? 1 : 0);
      end
      sel = 3'($urandom_range(0, 7));
    end

    // Pause after two dwell cycles on channel 3
    mode = 1'b0; sel = 3'd3; step();
    mode = 1'b1; step();
    step();
    held = int'(out0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rand_in();
      step();
      chk("pause_out", int'(out0), held);
      chk("pause_valid", int'(v0), 0);
    end
    en = 1'b1;
    step(); chk("resume_ch_a", int'(ch0), 3);
    step(); chk("resume_ch_b", int'(ch0), 3);
    step(); chk("resume_ch_c", int'(ch0), 4);

    // Mode drops while disabled: next scan entry reloads from sel
    en = 1'b0; step();
    mode = 1'b0; step();
    mode = 1'b1; sel = 3'd2; en = 1'b1; step();
    chk("reload_ch", int'(ch0), 2);

    // Scan -> manual shows the selected channel immediately
    mode = 1'b0; sel = 3'd1; rand_in(); step();
    chk("to_manual_ch", int'(ch0), 1);

    // Random mixed traffic
    for (int k = 0; k < 300; k++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      sel  = 3'($urandom_range(0, 7));
      rand_in();
      step();
    end

    // Asynchronous reset mid-scan, mid-cycle
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_in();
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_valid", int'(v0), 0);
    step();
    rst_n = 1'b1;
    sel = 3'd4;
    for (int k = 0; k < 8; k++) begin
      rand_in();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per input channel, minimum 1.
REQ-002 SHALL have parameter CHANNELS, default 8: number of input channels, range 2..256.
REQ-003 SHALL have parameter DWELL, default 4: clock cycles spent on each channel in scan mode, minimum 1.
REQ-004 SHALL have derived localparam SELW = clog2(CHANNELS), not overridable.
REQ-005 SHALL have ports clk (input, 1): the single clock, rising-edge active.
REQ-006 SHALL have port rst_n (input, 1): asynchronous, active-low reset.
REQ-007 SHALL have port in (input, CHANNELS*WIDTH): packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel (input, SELW): channel select in manual mode, and scan start channel.
REQ-009 SHALL have port mode (input, 1): 0 = manual, 1 = auto-scan.
REQ-010 SHALL have port en (input, 1): global enable.
REQ-011 SHALL have port out (output, WIDTH): registered selected data.
REQ-012 SHALL have port out_ch (output, SELW): channel index that produced out.
REQ-013 SHALL have port out_valid (output, 1): out/out_ch hold a fresh sample this cycle.
REQ-014 SHALL have port wrap (output, 1): one-cycle pulse when the scan returns from channel CHANNELS-1 to 0.
REQ-015 SHALL have port sel_err (output, 1): registered flag; manual sel >= CHANNELS.

Function
REQ-016 SHALL use FSM states IDLE, MANUAL, SCAN; IDLE entered on reset.
REQ-017 SHALL move, with en=1 in any state, to MANUAL if mode=0 and to SCAN if mode=1, evaluated each clock; en=0 SHALL force IDLE.
REQ-018 SHALL, in IDLE, hold out and out_ch, drive out_valid=0 and wrap=0, and freeze the dwell counter.
REQ-019 SHALL, in MANUAL, register out<=in[sel], out_ch<=sel, out_valid<=1 each cycle: 1-cycle latency from sel/in to out.
REQ-020 SHALL, in MANUAL with sel >= CHANNELS, register out<=0, out_valid<=0, sel_err<=1; sel_err SHALL clear on the first cycle with valid sel or outside MANUAL.
REQ-021 SHALL, on entry to SCAN, load the scan channel with sel (or 0 if sel >= CHANNELS) and clear the dwell counter.
REQ-022 SHALL, in SCAN, register out<=in[scan channel], out_ch<=scan channel, out_valid<=1 every cycle.
REQ-023 SHALL, in SCAN, count dwell 0..DWELL-1; at DWELL-1 the counter SHALL return to 0 and the scan channel SHALL advance by 1 on the same edge.
REQ-024 SHALL wrap the scan channel from CHANNELS-1 to 0 (not 2^SELW-1) and assert wrap for exactly the cycle out_ch first shows 0 after the wrap.
REQ-025 SHALL, with DWELL=1, advance the channel every cycle with no idle cycle.
REQ-026 SHALL, on en falling mid-dwell, preserve scan channel and dwell count so re-enable in SCAN without a mode change resumes where stopped; a mode 0->1 transition SHALL reload per REQ-021.
REQ-027 SHALL, on SCAN->MANUAL, present in[sel] on the next edge with no stale scan sample.
REQ-028 SHALL have out/out_ch driven only from flops; no combinational input-to-output path.

Reset
REQ-029 SHALL, on rst_n low, asynchronously set out=0, out_ch=0, out_valid=0, wrap=0, sel_err=0, dwell=0, scan channel=0, state=IDLE.
REQ-030 SHALL, on reset mid-scan, discard the scan position; the first edge after release SHALL follow REQ-017.

Structure
REQ-031 SHALL place state encoding (IDLE/MANUAL/SCAN) and the clog2 function in shared package mux_pkg.
REQ-032 SHALL implement the dwell counter and scan channel in sub-module scan_counter (ports clk, rst_n, load, load_val, run, ch, wrap).

Verification
REQ-033 SHALL check reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
REQ-034 SHALL check manual: WIDTH=8, CHANNELS=8, in channel k = 8'h10+k, mode=0, en=1, sel=3'b110 -> next edge out=8'h16, out_ch=6, out_valid=1.
REQ-035 SHALL check scan: DWELL=4, sel=5 at entry -> out_ch 5 for 4 cycles, then 6, 7, 0 with wrap=1 on the first cycle of channel 0 only.
REQ-036 SHALL check non-power-of-2: CHANNELS=5, manual sel=6 -> out=0, out_valid=0, sel_err=1; scan wraps 4->0.
REQ-037 SHALL check pause: en=0 after 2 dwell cycles on channel 3 for 10 cycles -> out held, out_valid=0; en=1 -> 2 more cycles on channel 3, then channel 4.
REQ-038 SHALL check DWELL=1: out_ch increments every cycle, wrap every CHANNELS cycles.
